// File: rtl/btn_counter_arbiter.sv
// Shared W-bit LED counter serving N debounced push-button requesters in round-robin order.
// Define SATURATE_EN to clamp the counter at its limits instead of wrapping.
module btn_counter_arbiter #(
    parameter int             N             = 2,
    parameter int             W             = 4,
    parameter logic [N-1:0]   INC_MASK      = 2'b01,
    parameter int             STABLE_TICKS  = 3,
    parameter int             HOLDOFF_TICKS = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic [N-1:0] req,
    output logic [W-1:0] count,
    output logic [N-1:0] grant,
    output logic         busy,
    output logic         limit
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        UPD  = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t         state_reg, state_next;
    logic [N-1:0]   sync1_reg, sync2_reg;
    logic [N-1:0]   level_vec, rise_vec;
    logic [N-1:0]   pending_reg, pending_next;
    logic [N-1:0]   clr_vec, grant_vec;
    logic [IW-1:0]  idx_reg, idx_next;
    logic [IW-1:0]  last_reg, last_next;
    logic [IW-1:0]  sel;
    logic           found;
    logic [3:0]     hold_reg, hold_next;
    logic [W-1:0]   count_reg, count_next;
    logic [N-1:0]   grant_reg, grant_next;
    logic           limit_reg, limit_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= req;
            sync2_reg <= sync1_reg;
        end
    end

    // A new level is accepted only after STABLE_TICKS consecutive differing samples.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_deb
            logic [3:0] stab_reg;
            logic       lvl_reg;
            logic       differ;
            logic       accept;

            assign differ        = sync2_reg[gi] != lvl_reg;
            assign accept        = tick && differ && (stab_reg == 4'(STABLE_TICKS - 1));
            assign rise_vec[gi]  = accept && sync2_reg[gi];
            assign level_vec[gi] = lvl_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stab_reg <= '0;
                    lvl_reg  <= 1'b0;
                end else if (tick) begin
                    if (!differ) begin
                        stab_reg <= '0;
                    end else if (accept) begin
                        stab_reg <= '0;
                        lvl_reg  <= sync2_reg[gi];
                    end else begin
                        stab_reg <= stab_reg + 4'd1;
                    end
                end
            end
        end
    endgenerate

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        sel   = last_reg;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = int'(last_reg) + k;
            if (j >= N) j = j - N;
            if (!found && pending_reg[j[IW-1:0]]) begin
                sel   = j[IW-1:0];
                found = 1'b1;
            end
        end
    end

    assign grant_vec = N'(1) << idx_reg;

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        last_next  = last_reg;
        hold_next  = hold_reg;
        count_next = count_reg;
        grant_next = '0;
        limit_next = 1'b0;
        clr_vec    = '0;
        case (state_reg)
            IDLE: begin
                if (|pending_reg) state_next = ARB;
            end
            ARB: begin
                idx_next   = sel;
                last_next  = sel;
                state_next = UPD;
            end
            UPD: begin
                grant_next = grant_vec;
                clr_vec    = grant_vec;
                if (INC_MASK[idx_reg]) begin
                    if (count_reg == '1) begin
                        limit_next = 1'b1;
`ifdef SATURATE_EN
                        count_next = count_reg;
`else
                        count_next = '0;
`endif
                    end else begin
                        count_next = count_reg + W'(1);
                    end
                end else begin
                    if (count_reg == '0) begin
                        limit_next = 1'b1;
`ifdef SATURATE_EN
                        count_next = count_reg;
`else
                        count_next = '1;
`endif
                    end else begin
                        count_next = count_reg - W'(1);
                    end
                end
                if (HOLDOFF_TICKS > 0) state_next = HOLD;
                else                   state_next = IDLE;
            end
            HOLD: begin
                if (tick) begin
                    if (hold_reg == 4'(HOLDOFF_TICKS - 1)) begin
                        hold_next  = '0;
                        state_next = IDLE;
                    end else begin
                        hold_next = hold_reg + 4'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // A press landing on the grant cycle must survive the clear.
        pending_next = (pending_reg & ~clr_vec) | rise_vec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            pending_reg <= '0;
            idx_reg     <= '0;
            last_reg    <= IW'(N - 1);
            hold_reg    <= '0;
            count_reg   <= '0;
            grant_reg   <= '0;
            limit_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            idx_reg     <= idx_next;
            last_reg    <= last_next;
            hold_reg    <= hold_next;
            count_reg   <= count_next;
            grant_reg   <= grant_next;
            limit_reg   <= limit_next;
        end
    end

    assign count = count_reg;
    assign grant = grant_reg;
    assign limit = limit_reg;
    assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_btn_counter_arbiter.sv
// Bench for btn_counter_arbiter: cycle-level reference model plus directed press scenarios.
module tb_btn_counter_arbiter;

    localparam int N     = 2;
    localparam int W     = 4;
    localparam int STAB  = 3;
    localparam int HOLDT = 2;
    localparam int MAXV  = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tick = 1'b0;
    logic [N-1:0] req = '0;
    logic [W-1:0] count;
    logic [N-1:0] grant;
    logic         busy;
    logic         limit;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [N-1:0] inc_v;

    // reference model state
    logic [N-1:0] m_h0, m_h1, m_pend, m_lvl, m_grant;
    int           m_run[N];
    int           m_phase, m_win, m_last, m_ht, m_cnt;
    logic         m_limit;

    // observed-transaction monitors
    logic [N-1:0] g_hist[$];
    int           lim_cnt = 0;

    btn_counter_arbiter #(
        .N(N), .W(W), .INC_MASK(2'b01), .STABLE_TICKS(STAB), .HOLDOFF_TICKS(HOLDT)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .req(req),
        .count(count), .grant(grant), .busy(busy), .limit(limit)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            tick = (cyc % 4 == 0);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_h0 = '0; m_h1 = '0; m_pend = '0; m_lvl = '0; m_grant = '0; m_limit = 1'b0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
        m_phase = 0; m_win = 0; m_last = N - 1; m_ht = 0; m_cnt = 0;
    endtask

    // One clock of the specified behaviour, phases: 0 idle, 1 arbitrate, 2 apply, 3 hold-off.
    task automatic model_step();
        logic [N-1:0] old_p, sampled, rise, clr;
        int nv;
        bit found;
        if (rst) begin
            model_reset();
            return;
        end
        old_p   = m_pend;
        sampled = m_h1;
        m_h1    = m_h0;
        m_h0    = req;
        rise    = '0;
        clr     = '0;
        if (tick) begin
            for (int i = 0; i < N; i++) begin
                if (sampled[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == STAB) begin
                        m_lvl[i] = sampled[i];
                        m_run[i] = 0;
                        if (sampled[i]) rise[i] = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
        m_grant = '0;
        m_limit = 1'b0;
        case (m_phase)
            0: if (old_p != 0) m_phase = 1;
            1: begin
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (!found && old_p[c]) begin
                        m_win = c;
                        found = 1;
                    end
                end
                m_last  = m_win;
                m_phase = 2;
            end
            2: begin
                nv = m_cnt + (inc_v[m_win] ? 1 : -1);
                if (nv < 0 || nv > MAXV) begin
                    m_limit = 1'b1;
`ifdef SATURATE_EN
                    nv = m_cnt;
`else
                    nv = (nv + MAXV + 1) % (MAXV + 1);
`endif
                end
                m_cnt        = nv;
                m_grant      = '0;
                m_grant[m_win] = 1'b1;
                clr          = m_grant;
                m_ht         = 0;
                m_phase      = (HOLDT > 0) ? 3 : 0;
            end
            default: begin
                if (tick) begin
                    m_ht++;
                    if (m_ht == HOLDT) begin
                        m_ht    = 0;
                        m_phase = 0;
                    end
                end
            end
        endcase
        m_pend = (old_p & ~clr) | rise;
    endtask

    // Compare process: model advances on each rising edge, DUT checked 2 time units later.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            model_step();
            #2;
            chk("count", int'(count), m_cnt);
            chk("grant", int'(grant), int'(m_grant));
            chk("busy", int'(busy), int'(m_phase != 0));
            chk("limit", int'(limit), int'(m_limit));
            if (grant != 0) begin
                g_hist.push_back(grant);
                $display("grant=%b count=%0d limit=%0b t=%0t", grant, count, limit, $time);
            end
            if (limit) lim_cnt++;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        wait_cycles(3);
        rst = 1'b0;
        g_hist.delete();
        lim_cnt = 0;
    endtask

    task automatic press(input logic [N-1:0] mask, input int hold);
        @(negedge clk);
        req = mask;
        wait_cycles(hold);
        req = '0;
        wait_cycles(30);
    endtask

    initial begin
        inc_v = 2'b01;
        wait_cycles(3);
        rst = 1'b0;

        // reset state
        do_reset();
        chk("rst_count", int'(count), 0);
        chk("rst_grant", int'(grant), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_limit", int'(limit), 0);

        // single press held: exactly one increment
        @(negedge clk);
        req = 2'b01;
        wait_cycles(28);
        chk("t1_ngrant", g_hist.size(), 1);
        if (g_hist.size() > 0) chk("t1_grant", int'(g_hist[0]), 1);
        chk("t1_count", int'(count), 1);
        wait_cycles(40);
        chk("t1_held_ngrant", g_hist.size(), 1);
        req = '0;
        wait_cycles(30);

        // short glitch is rejected
        do_reset();
        @(negedge clk);
        req = 2'b01;
        wait_cycles(6);
        req = '0;
        wait_cycles(40);
        chk("t2_ngrant", g_hist.size(), 0);
        chk("t2_count", int'(count), 0);

        // simultaneous presses: requester 0 first, then 1
        do_reset();
        press(2'b11, 28);
        wait_cycles(20);
        chk("t3_ngrant", g_hist.size(), 2);
        if (g_hist.size() > 1) begin
            chk("t3_first", int'(g_hist[0]), 1);
            chk("t3_second", int'(g_hist[1]), 2);
        end
        chk("t3_count", int'(count), 0);

        // decrement below zero, then increment back
        do_reset();
        press(2'b10, 28);
        chk("t4_ngrant", g_hist.size(), 1);
        if (g_hist.size() > 0) chk("t4_grant", int'(g_hist[0]), 2);
        chk("t4_lim1", lim_cnt, 1);
`ifdef SATURATE_EN
        chk("t4_count_clamp", int'(count), 0);
        press(2'b01, 28);
        chk("t4_count_up", int'(count), 1);
        chk("t4_lim2", lim_cnt, 1);
`else
        chk("t4_count_wrap", int'(count), MAXV);
        press(2'b01, 28);
        chk("t4_count_back", int'(count), 0);
        chk("t4_lim2", lim_cnt, 2);
`endif

        // async reset during hold-off with requester 0 pending
        do_reset();
        @(negedge clk);
        req = 2'b10;
        wait_cycles(4);
        req = 2'b11;
        begin
            int n;
            n = 0;
            while (g_hist.size() == 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("t6_grant_timeout", int'(g_hist.size() != 0), 1);
        end
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        req = '0;
        #1;
        chk("t6_count", int'(count), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_grant", int'(grant), 0);
        wait_cycles(2);
        rst = 1'b0;
        g_hist.delete();
        wait_cycles(60);
        chk("t6_after_ngrant", g_hist.size(), 0);
        chk("t6_after_count", int'(count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
